// File: rtl/bus_cmd_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the byte-stream
// bus command initiator.
package bus_cmd_pkg;

  localparam logic [7:0] OP_READ      = 8'h01;
  localparam logic [7:0] OP_WRITE     = 8'h02;

  localparam logic [7:0] RSP_WR_OK    = 8'hAA;
  localparam logic [7:0] RSP_BAD_OP   = 8'hE1;
  localparam logic [7:0] RSP_MISALIGN = 8'hE2;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/bus_cmd_initiator.sv
// Turns a byte command stream (read/write, 32-bit address and data) into a
// single memory-bus request and streams the result back as response bytes.
module bus_cmd_initiator
  import bus_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_rx_en;
  logic          r_is_write;
  logic [1:0]    r_byte_idx;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [TW-1:0] r_timer;
  logic          r_mem_valid;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic [1:0]    r_tx_left;

  logic          w_rx_fire;
  logic          w_tx_fire;
  logic          w_resp_load;
  logic          w_resp_read;
  logic [7:0]    w_resp_byte;

  // rx_ready stays low until the first edge after reset release.
  assign rx_ready    = r_rx_en && (r_state == ST_IDLE || r_state == ST_ADDR || r_state == ST_DATA);
  assign w_rx_fire   = rx_valid && rx_ready;
  assign w_tx_fire   = r_tx_valid && tx_ready;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = (r_mem_valid && r_is_write) ? 4'hF : 4'h0;
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_resp_load  = 1'b0;
    w_resp_read  = 1'b0;
    w_resp_byte  = RSP_WR_OK;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_fire) begin
          if (rx_data == OP_READ || rx_data == OP_WRITE) begin
            w_state_next = ST_ADDR;
          end else begin
            w_state_next = ST_RESP;
            w_resp_load  = 1'b1;
            w_resp_byte  = RSP_BAD_OP;
          end
        end
      end
      ST_ADDR: begin
        if (w_rx_fire && r_byte_idx == 2'd3) begin
          // The last address byte carries addr[1:0]; reject before any bus cycle.
          if (rx_data[1:0] != 2'b00) begin
            w_state_next = ST_RESP;
            w_resp_load  = 1'b1;
            w_resp_byte  = RSP_MISALIGN;
          end else if (r_is_write) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_BUS;
          end
        end
      end
      ST_DATA: begin
        if (w_rx_fire && r_byte_idx == 2'd3) w_state_next = ST_BUS;
      end
      ST_BUS: begin
        if (mem_ready_i) begin
          w_state_next = ST_RESP;
          w_resp_load  = 1'b1;
          w_resp_read  = !r_is_write;
          w_resp_byte  = r_is_write ? RSP_WR_OK : mem_rdata_i[31:24];
        end else if (r_timer == TIMER_LAST) begin
          w_state_next = ST_RESP;
          w_resp_load  = 1'b1;
          w_resp_byte  = RSP_TIMEOUT;
        end
      end
      ST_RESP: begin
        if (w_tx_fire && r_tx_left == 2'd0) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_en     <= 1'b0;
      r_is_write  <= 1'b0;
      r_byte_idx  <= 2'd0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_timer     <= '0;
      r_mem_valid <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_tx_left   <= 2'd0;
    end else begin
      r_rx_en <= 1'b1;
      if (r_state == ST_IDLE && w_rx_fire) begin
        r_is_write <= (rx_data == OP_WRITE);
        r_byte_idx <= 2'd0;
      end
      if (r_state == ST_ADDR && w_rx_fire) begin
        r_addr     <= {r_addr[23:0], rx_data};
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (r_state == ST_DATA && w_rx_fire) begin
        r_wdata    <= {r_wdata[23:0], rx_data};
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (r_state != ST_BUS && w_state_next == ST_BUS) begin
        r_mem_valid <= 1'b1;
        r_timer     <= '0;
      end
      if (r_state == ST_BUS) begin
        if (w_state_next != ST_BUS) r_mem_valid <= 1'b0;
        else                        r_timer     <= r_timer + TW'(1);
      end
      // Remaining read bytes are kept left-justified so the next byte is always [31:24].
      if (w_resp_load) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_resp_byte;
        r_tx_left  <= w_resp_read ? 2'd3 : 2'd0;
        if (w_resp_read) r_rdata <= {mem_rdata_i[23:0], 8'h00};
      end else if (r_state == ST_RESP && w_tx_fire) begin
        if (r_tx_left == 2'd0) begin
          r_tx_valid <= 1'b0;
        end else begin
          r_tx_data <= r_rdata[31:24];
          r_rdata   <= {r_rdata[23:0], 8'h00};
          r_tx_left <= r_tx_left - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_cmd_initiator.sv
// Scoreboard bench for bus_cmd_initiator: expected response bytes are queued
// as commands are driven and popped as the DUT emits them.
module tb_bus_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic        busy;

  bus_cmd_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  int          resp_delay  = 3;
  logic        resp_silent = 1'b0;
  logic [31:0] resp_data   = 32'h0;

  int          req_cnt   = 0;
  int          vcnt      = 0;
  int          last_vcnt = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Responder: pulses mem_ready_i during the resp_delay-th cycle of a request.
  initial begin
    int rcnt = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready_i = 1'b0;
      if (reset || !mem_valid_o) begin
        rcnt = 0;
      end else begin
        rcnt++;
        if (!resp_silent && rcnt == resp_delay) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = resp_data;
        end
      end
    end
  end

  // Monitor: tx scoreboard, backpressure hold, bus request tracking.
  initial begin
    logic       prev_valid = 1'b0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        hold_v     = 1'b0;
      end else begin
        if (hold_v) chk("bp_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, hold_d});
        hold_v = tx_valid && !tx_ready;
        hold_d = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) chk("tx_unexpected", exp_q.size(), 1);
          else                   chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
        if (mem_valid_o) begin
          if (!prev_valid) begin
            req_cnt++;
            vcnt      = 1;
            cap_addr  = mem_addr_o;
            cap_wdata = mem_wdata_o;
            cap_wstrb = mem_wstrb_o;
          end else begin
            vcnt++;
            if (mem_addr_o !== cap_addr || mem_wdata_o !== cap_wdata || mem_wstrb_o !== cap_wstrb)
              chk("bus_stable", mem_addr_o ^ cap_addr ^ mem_wdata_o ^ cap_wdata, 0);
          end
        end else if (prev_valid) begin
          last_vcnt = vcnt;
        end
        prev_valid = mem_valid_o;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) chk("rx_ready_wait", {31'h0, rx_ready}, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
    send_byte(op);
    if (op == 8'h01 || op == 8'h02) begin
      for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
      if (op == 8'h02)
        for (int i = 3; i >= 0; i--) send_byte(wd[i*8 +: 8]);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_idle"}, {31'h0, busy}, 0);
  endtask

  initial begin
    int base;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_valid", {31'h0, mem_valid_o}, 0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_rx_ready", {31'h0, rx_ready}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_wstrb", {28'h0, mem_wstrb_o}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("rx_ready_after_rst", {31'h0, rx_ready}, 1);

    // Read 0x0C, responder answers 0x155 on third request cycle.
    base = req_cnt; resp_delay = 3; resp_data = 32'h0000_0155;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h55);
    send_cmd(8'h01, 32'h0000_000C, 32'h0);
    drain("read");
    chk("read_reqs", req_cnt - base, 1);
    chk("read_addr", cap_addr, 32'h0000_000C);
    chk("read_wstrb", {28'h0, cap_wstrb}, 0);
    chk("read_vcycles", last_vcnt, 3);

    // Write 0x1F4 to 0x0, immediate ready.
    base = req_cnt; resp_delay = 1;
    exp_q.push_back(8'hAA);
    send_cmd(8'h02, 32'h0, 32'h0000_01F4);
    drain("write");
    chk("write_reqs", req_cnt - base, 1);
    chk("write_addr", cap_addr, 0);
    chk("write_wdata", cap_wdata, 32'h0000_01F4);
    chk("write_wstrb", {28'h0, cap_wstrb}, 32'hF);
    chk("write_vcycles", last_vcnt, 1);

    // Bad opcode, then misaligned read with no bus activity.
    base = req_cnt;
    exp_q.push_back(8'hE1);
    send_cmd(8'h07, 32'h0, 32'h0);
    drain("badop");
    exp_q.push_back(8'hE2);
    send_cmd(8'h01, 32'h0000_0006, 32'h0);
    drain("misalign");
    chk("err_no_bus", req_cnt - base, 0);

    // Silent responder: timeout after exactly 8 request cycles.
    base = req_cnt; resp_silent = 1'b1;
    exp_q.push_back(8'hEE);
    send_cmd(8'h01, 32'h0000_0010, 32'h0);
    drain("timeout");
    chk("timeout_vcycles", last_vcnt, 8);
    chk("timeout_reqs", req_cnt - base, 1);

    // Ready on the final count beats the timeout.
    resp_silent = 1'b0; resp_delay = 8; resp_data = 32'h1234_5678;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    send_cmd(8'h01, 32'h0000_0020, 32'h0);
    drain("ready_last");
    chk("ready_last_vcycles", last_vcnt, 8);

    // Backpressure: 5-cycle stall after first response byte.
    resp_delay = 2; resp_data = 32'hDEAD_BEEF; tx_ready = 1'b0;
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD); exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    send_cmd(8'h01, 32'h0000_0040, 32'h0);
    for (int k = 0; k < 100 && !tx_valid; k++) begin
      @(posedge clk); #2;
    end
    tx_ready = 1'b1;
    @(posedge clk); #2 tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #2 tx_ready = 1'b1;
    drain("backpressure");

    // Asynchronous reset while the request is outstanding.
    resp_silent = 1'b1;
    send_cmd(8'h01, 32'h0000_0080, 32'h0);
    for (int k = 0; k < 50 && !mem_valid_o; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_valid", {31'h0, mem_valid_o}, 0);
    chk("arst_tx_valid", {31'h0, tx_valid}, 0);
    chk("arst_busy", {31'h0, busy}, 0);
    chk("arst_rx_ready", {31'h0, rx_ready}, 0);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    #1 chk("rx_ready_before_edge", {31'h0, rx_ready}, 0);
    @(posedge clk); #1;
    chk("rx_ready_after_arst", {31'h0, rx_ready}, 1);

    resp_silent = 1'b0; resp_delay = 2;
    exp_q.push_back(8'hAA);
    send_cmd(8'h02, 32'h0000_0100, 32'hCAFE_F00D);
    drain("post_reset");
    chk("post_reset_wdata", cap_wdata, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_cmd_initiator.md
BUS_CMD_INITIATOR -- requirements
Module: bus_cmd_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles mem_valid_o is held waiting for mem_ready_i.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  command stream byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  block accepts rx_data this cycle.
REQ-007 SHALL have port tx_data  output  8  response stream byte.
REQ-008 SHALL have port tx_valid  output  1  tx_data valid.
REQ-009 SHALL have port tx_ready  input  1  downstream accepts tx_data.
REQ-010 SHALL have port mem_valid_o  output  1  bus request to peripheral responders.
REQ-011 SHALL have port mem_ready_i  input  1  single-cycle responder completion pulse.
REQ-012 SHALL have ports mem_addr_o  output  32, mem_wdata_o  output  32, mem_wstrb_o  output  4, mem_rdata_i  input  32.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL transfer a byte on rx only when rx_valid and rx_ready are both high, and on tx only when tx_valid and tx_ready are both high.
REQ-015 SHALL use states IDLE, ADDR, DATA, BUS, RESP.
REQ-016 IDLE: rx_ready=1; opcode 0x01 (read) or 0x02 (write) -> ADDR; any other opcode -> RESP with single byte 0xE1.
REQ-017 ADDR: accept 4 address bytes, MSB first; after 4th: misaligned (addr[1:0]!=0) -> RESP with 0xE2, no bus cycle; write -> DATA; read -> BUS.
REQ-018 DATA: accept 4 write-data bytes, MSB first, then -> BUS.
REQ-019 BUS: mem_valid_o=1 from the first BUS cycle; mem_addr_o/mem_wdata_o/mem_wstrb_o stable while mem_valid_o high; mem_wstrb_o=4'hF for write, 4'h0 for read.
REQ-020 On the cycle mem_ready_i=1 seen in BUS, SHALL capture mem_rdata_i (reads), deassert mem_valid_o on the next cycle, and go to RESP.
REQ-021 mem_valid_o SHALL be low for at least one cycle between two bus requests.
REQ-022 Timeout counter SHALL count BUS cycles; if TIMEOUT_CYCLES cycles elapse without mem_ready_i, SHALL drop mem_valid_o and go to RESP with byte 0xEE; mem_ready_i coincident with the final count SHALL win over timeout.
REQ-023 RESP: read success -> 4 bytes of captured data, MSB first; write success -> single byte 0xAA; error -> single error code; rx_ready=0 throughout.
REQ-024 tx_data/tx_valid SHALL hold while tx_ready=0 (backpressure); after last byte accepted -> IDLE.
REQ-025 rx_ready SHALL be 0 in BUS and RESP; rx_ready=1 in IDLE, ADDR, DATA.
REQ-026 mem_ready_i outside BUS SHALL be ignored.

Reset
REQ-027 On reset assertion SHALL immediately force state IDLE, mem_valid_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0, tx_valid=0, tx_data=0, rx_ready=0, busy=0, counters and byte index 0.
REQ-028 Reset mid-transaction SHALL abandon it with no response byte; rx_ready=1 from first clock edge after deassertion.

Structure
REQ-029 Opcodes (0x01, 0x02), response codes (0xAA, 0xE1, 0xE2, 0xEE) and state encoding SHALL live in a shared bus_cmd_pkg.
REQ-030 Single module; no sub-modules required.

Verification
REQ-031 Read: bytes 01 00 00 00 0C, responder returns 0x00000155 after 3 cycles -> mem_wstrb_o=0, tx bytes 00 00 01 55.
REQ-032 Write: 02 00 00 00 00 00 00 01 F4 -> one bus cycle addr 0x0, wdata 0x1F4, wstrb 0xF; tx 0xAA; mem_valid_o low next cycle after ready.
REQ-033 Errors: opcode 0x07 -> tx 0xE1; read addr 0x00000006 -> tx 0xE2 with mem_valid_o never high.
REQ-034 Timeout: TIMEOUT_CYCLES=8, responder silent -> mem_valid_o high exactly 8 cycles, tx 0xEE; ready on 8th cycle -> normal response.
REQ-035 Backpressure: tx_ready low 5 cycles mid read response -> tx_data stable, no byte lost or duplicated.
REQ-036 Reset asserted in BUS state -> mem_valid_o and tx_valid drop asynchronously; next command completes normally.
